// File: rtl/otter_dmem_arbiter.sv
// rtl/otter_dmem_arbiter.sv - OTTER data-port (port 2) arbiter between CPU memory stage and debug loader
module otter_dmem_arbiter #(
   parameter int MAX_WAIT = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CPU_REQ,
   input  logic [31:0] CPU_ADDR,
   input  logic        CPU_WE,
   input  logic [1:0]  CPU_SIZE,
   input  logic        CPU_SIGN,
   input  logic [31:0] CPU_DIN,
   output logic        CPU_GNT,
   output logic        CPU_RVALID,
   output logic [31:0] CPU_DOUT,
   input  logic        DBG_REQ,
   input  logic [31:0] DBG_ADDR,
   input  logic        DBG_WE,
   input  logic [1:0]  DBG_SIZE,
   input  logic        DBG_SIGN,
   input  logic [31:0] DBG_DIN,
   input  logic        DBG_LOCK,
   output logic        DBG_GNT,
   output logic        DBG_RVALID,
   output logic [31:0] DBG_DOUT,
   output logic [31:0] MEM_ADDR2,
   output logic [31:0] MEM_DIN2,
   output logic        MEM_WRITE2,
   output logic        MEM_READ2,
   output logic [1:0]  MEM_SIZE,
   output logic        MEM_SIGN,
   input  logic [31:0] MEM_DOUT2
);

   typedef enum logic [1:0] {ARB, FORCE, LOCKED} state_t;

   localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_nxt;
   logic       cpu_gnt, dbg_gnt;
   logic       rd_cpu, rd_dbg;

   always_comb begin
      state_nxt = state;
      wait_nxt  = 8'd0;
      cpu_gnt   = 1'b0;
      dbg_gnt   = 1'b0;
      case (state)
         ARB: begin
            if (CPU_REQ)
               cpu_gnt = 1'b1;
            else if (DBG_REQ)
               dbg_gnt = 1'b1;
            if (DBG_REQ && !dbg_gnt)
               wait_nxt = (wait_cnt >= WAIT_LIM) ? WAIT_LIM : wait_cnt + 8'd1;
            // A loader grant in ARB clears wait_nxt, so a simultaneous reach skips FORCE
            if (dbg_gnt && DBG_LOCK)
               state_nxt = LOCKED;
            else if (wait_nxt == WAIT_LIM)
               state_nxt = FORCE;
         end
         FORCE: begin
            if (DBG_REQ) begin
               dbg_gnt   = 1'b1;
               state_nxt = DBG_LOCK ? LOCKED : ARB;
            end else begin
               cpu_gnt   = CPU_REQ;
               state_nxt = ARB;
            end
         end
         LOCKED: begin
            dbg_gnt = DBG_REQ;
            if (!DBG_LOCK)
               state_nxt = ARB;
         end
         default: state_nxt = ARB;
      endcase
      if (RST) begin
         cpu_gnt = 1'b0;
         dbg_gnt = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ARB;
         wait_cnt <= 8'd0;
         rd_cpu   <= 1'b0;
         rd_dbg   <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         rd_cpu   <= cpu_gnt & ~CPU_WE;
         rd_dbg   <= dbg_gnt & ~DBG_WE;
      end
   end

   // CPU fields are the idle default on the memory port
   assign MEM_ADDR2  = dbg_gnt ? DBG_ADDR : CPU_ADDR;
   assign MEM_DIN2   = dbg_gnt ? DBG_DIN  : CPU_DIN;
   assign MEM_SIZE   = dbg_gnt ? DBG_SIZE : CPU_SIZE;
   assign MEM_SIGN   = dbg_gnt ? DBG_SIGN : CPU_SIGN;
   assign MEM_WRITE2 = (cpu_gnt & CPU_WE)  | (dbg_gnt & DBG_WE);
   assign MEM_READ2  = (cpu_gnt & ~CPU_WE) | (dbg_gnt & ~DBG_WE);

   assign CPU_GNT    = cpu_gnt;
   assign DBG_GNT    = dbg_gnt;
   // Masking with RST kills the return of a read issued just before reset
   assign CPU_RVALID = rd_cpu & ~RST;
   assign DBG_RVALID = rd_dbg & ~RST;
   assign CPU_DOUT   = MEM_DOUT2;
   assign DBG_DOUT   = MEM_DOUT2;

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// tb/tb_otter_dmem_arbiter.sv - directed self-checking bench for otter_dmem_arbiter
module tb_otter_dmem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CPU_REQ, CPU_WE, CPU_SIGN;
   logic [31:0] CPU_ADDR, CPU_DIN;
   logic [1:0]  CPU_SIZE;
   logic        CPU_GNT, CPU_RVALID;
   logic [31:0] CPU_DOUT;
   logic        DBG_REQ, DBG_WE, DBG_SIGN, DBG_LOCK;
   logic [31:0] DBG_ADDR, DBG_DIN;
   logic [1:0]  DBG_SIZE;
   logic        DBG_GNT, DBG_RVALID;
   logic [31:0] DBG_DOUT;
   logic [31:0] MEM_ADDR2, MEM_DIN2;
   logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
   logic [1:0]  MEM_SIZE;
   logic [31:0] mem_dout;

   int total;
   int bad;

   always #5 CLK = ~CLK;

   otter_dmem_arbiter #(.MAX_WAIT(4)) dut (
      .CLK(CLK), .RST(RST),
      .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_WE(CPU_WE), .CPU_SIZE(CPU_SIZE),
      .CPU_SIGN(CPU_SIGN), .CPU_DIN(CPU_DIN), .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID),
      .CPU_DOUT(CPU_DOUT),
      .DBG_REQ(DBG_REQ), .DBG_ADDR(DBG_ADDR), .DBG_WE(DBG_WE), .DBG_SIZE(DBG_SIZE),
      .DBG_SIGN(DBG_SIGN), .DBG_DIN(DBG_DIN), .DBG_LOCK(DBG_LOCK), .DBG_GNT(DBG_GNT),
      .DBG_RVALID(DBG_RVALID), .DBG_DOUT(DBG_DOUT),
      .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
      .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
      .MEM_DOUT2(mem_dout)
   );

   // Byte-addressed memory with registered, sliced read data
   logic [7:0] mem [0:1023];
   logic [9:0] wa;
   assign wa = MEM_ADDR2[9:0];

   function automatic logic [31:0] rd_slice(input logic [9:0] a, input logic [1:0] sz,
                                            input logic uns);
      logic [31:0] w;
      w = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
      case (sz)
         2'd0:    rd_slice = uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
         2'd1:    rd_slice = uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: rd_slice = w;
      endcase
   endfunction

   always @(posedge CLK) begin
      if (MEM_WRITE2) begin
         mem[wa] <= MEM_DIN2[7:0];
         if (MEM_SIZE != 2'd0) mem[wa + 10'd1] <= MEM_DIN2[15:8];
         if (MEM_SIZE == 2'd2) begin
            mem[wa + 10'd2] <= MEM_DIN2[23:16];
            mem[wa + 10'd3] <= MEM_DIN2[31:24];
         end
      end
      if (MEM_READ2) mem_dout <= rd_slice(wa, MEM_SIZE, MEM_SIGN);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic cpu_rq(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] din);
      CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = addr; CPU_SIZE = sz; CPU_SIGN = sgn; CPU_DIN = din;
   endtask

   task automatic dbg_rq(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] din);
      DBG_REQ = 1'b1; DBG_WE = we; DBG_ADDR = addr; DBG_SIZE = sz; DBG_SIGN = sgn; DBG_DIN = din;
   endtask

   task automatic idle();
      CPU_REQ = 1'b0; DBG_REQ = 1'b0; DBG_LOCK = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      total = 0; bad = 0;
      RST = 1'b1;
      CPU_REQ = 0; CPU_WE = 0; CPU_ADDR = 0; CPU_SIZE = 0; CPU_SIGN = 0; CPU_DIN = 0;
      DBG_REQ = 0; DBG_WE = 0; DBG_ADDR = 0; DBG_SIZE = 0; DBG_SIGN = 0; DBG_DIN = 0;
      DBG_LOCK = 0;
      next_cycle();

      // reset holds every grant and memory strobe low
      cpu_rq(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      dbg_rq(1'b1, 32'h555, 2'd2, 1'b0, 32'h0);
      DBG_LOCK = 1'b1;
      #1;
      check("rst_cpu_gnt", 32'(CPU_GNT), 0);
      check("rst_dbg_gnt", 32'(DBG_GNT), 0);
      check("rst_mem_rd", 32'(MEM_READ2), 0);
      check("rst_mem_wr", 32'(MEM_WRITE2), 0);
      next_cycle();
      RST = 1'b0;
      idle();
      #1;
      check("post_rst_cpu_rv", 32'(CPU_RVALID), 0);
      check("post_rst_dbg_rv", 32'(DBG_RVALID), 0);
      check("idle_mem_rd", 32'(MEM_READ2), 0);
      check("idle_mem_wr", 32'(MEM_WRITE2), 0);
      check("idle_addr_cpu", MEM_ADDR2, 32'h100);

      // CPU only: store then load 0x100
      cpu_rq(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF);
      #1;
      check("t1_sw_gnt", 32'(CPU_GNT), 1);
      check("t1_sw_wr", 32'(MEM_WRITE2), 1);
      check("t1_sw_rd", 32'(MEM_READ2), 0);
      next_cycle();
      cpu_rq(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      #1;
      check("t1_lw_gnt", 32'(CPU_GNT), 1);
      check("t1_lw_rd", 32'(MEM_READ2), 1);
      check("t1_lw_addr", MEM_ADDR2, 32'h100);
      check("t1_no_rv_after_sw", 32'(CPU_RVALID), 0);
      next_cycle();
      idle();
      #1;
      check("t1_cpu_rv", 32'(CPU_RVALID), 1);
      check("t1_cpu_dout", CPU_DOUT, 32'hDEADBEEF);
      check("t1_dbg_rv", 32'(DBG_RVALID), 0);
      next_cycle();

      // Interleave: CPU store, then loader load of the same word
      cpu_rq(1'b1, 32'h200, 2'd2, 1'b0, 32'h11223344);
      #1;
      check("t2_cpu_gnt", 32'(CPU_GNT), 1);
      next_cycle();
      CPU_REQ = 1'b0;
      dbg_rq(1'b0, 32'h200, 2'd2, 1'b0, 32'h0);
      #1;
      check("t2_dbg_gnt", 32'(DBG_GNT), 1);
      check("t2_cpu_gnt0", 32'(CPU_GNT), 0);
      check("t2_mem_rd", 32'(MEM_READ2), 1);
      check("t2_addr", MEM_ADDR2, 32'h200);
      next_cycle();
      idle();
      #1;
      check("t2_dbg_rv", 32'(DBG_RVALID), 1);
      check("t2_cpu_rv", 32'(CPU_RVALID), 0);
      check("t2_dbg_dout", DBG_DOUT, 32'h11223344);
      next_cycle();

      // Starvation with MAX_WAIT = 4: loader wins only in cycle 4
      cpu_rq(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      dbg_rq(1'b0, 32'h200, 2'd2, 1'b0, 32'h0);
      for (int c = 0; c < 6; c++) begin
         #1;
         check($sformatf("t3_cpu_gnt_c%0d", c), 32'(CPU_GNT), (c != 4) ? 1 : 0);
         check($sformatf("t3_dbg_gnt_c%0d", c), 32'(DBG_GNT), (c == 4) ? 1 : 0);
         check($sformatf("t3_cpu_rv_c%0d", c), 32'(CPU_RVALID), (c > 0 && c != 5) ? 1 : 0);
         check($sformatf("t3_dbg_rv_c%0d", c), 32'(DBG_RVALID), (c == 5) ? 1 : 0);
         next_cycle();
      end
      idle();
      next_cycle();

      // Simultaneous reach: CPU drops the cycle the count would hit the limit
      cpu_rq(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      dbg_rq(1'b0, 32'h200, 2'd2, 1'b0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("t3b_cpu_gnt_c%0d", c), 32'(CPU_GNT), 1);
         next_cycle();
      end
      CPU_REQ = 1'b0;
      #1;
      check("t3b_dbg_gnt_arb", 32'(DBG_GNT), 1);
      next_cycle();
      CPU_REQ = 1'b1;
      #1;
      check("t3b_no_force_cpu", 32'(CPU_GNT), 1);
      check("t3b_no_force_dbg", 32'(DBG_GNT), 0);
      next_cycle();
      idle();
      next_cycle();

      // Lock burst: 16 stores while the CPU keeps requesting
      cpu_rq(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      dbg_rq(1'b1, 32'h0, 2'd2, 1'b0, 32'hA5000000);
      DBG_LOCK = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         check($sformatf("t4_pre_cpu_c%0d", c), 32'(CPU_GNT), 1);
         check($sformatf("t4_pre_dbg_c%0d", c), 32'(DBG_GNT), 0);
         next_cycle();
      end
      for (int i = 0; i < 16; i++) begin
         DBG_ADDR = 32'(i * 4);
         DBG_DIN  = 32'hA5000000 + 32'(i);
         DBG_LOCK = (i != 15);
         #1;
         check($sformatf("t4_dbg_gnt_%0d", i), 32'(DBG_GNT), 1);
         check($sformatf("t4_cpu_gnt_%0d", i), 32'(CPU_GNT), 0);
         check($sformatf("t4_mem_wr_%0d", i), 32'(MEM_WRITE2), 1);
         next_cycle();
      end
      DBG_REQ = 1'b0;
      #1;
      check("t4_cpu_after_lock", 32'(CPU_GNT), 1);
      next_cycle();
      for (int i = 0; i < 16; i++) begin
         cpu_rq(1'b0, 32'(i * 4), 2'd2, 1'b0, 32'h0);
         next_cycle();
         CPU_REQ = 1'b0;
         #1;
         check($sformatf("t4_rb_%0d", i), CPU_DOUT, 32'hA5000000 + 32'(i));
         next_cycle();
      end

      // Reset mid-read
      cpu_rq(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      #1;
      check("t5_cpu_gnt", 32'(CPU_GNT), 1);
      next_cycle();
      RST = 1'b1;
      idle();
      #1;
      check("t5_rv_killed", 32'(CPU_RVALID), 0);
      next_cycle();
      RST = 1'b0;
      dbg_rq(1'b0, 32'h200, 2'd2, 1'b0, 32'h0);
      #1;
      check("t5_dbg_gnt", 32'(DBG_GNT), 1);
      next_cycle();
      idle();
      #1;
      check("t5_dbg_rv", 32'(DBG_RVALID), 1);
      check("t5_dbg_dout", DBG_DOUT, 32'h11223344);
      next_cycle();

      // Byte passthrough: loader sb, CPU lbu
      dbg_rq(1'b1, 32'h302, 2'd0, 1'b0, 32'h000000AB);
      #1;
      check("t6_dbg_gnt", 32'(DBG_GNT), 1);
      check("t6_size", 32'(MEM_SIZE), 0);
      check("t6_addr", MEM_ADDR2, 32'h302);
      check("t6_wr", 32'(MEM_WRITE2), 1);
      next_cycle();
      DBG_REQ = 1'b0;
      cpu_rq(1'b0, 32'h302, 2'd0, 1'b1, 32'h0);
      #1;
      check("t6_cpu_gnt", 32'(CPU_GNT), 1);
      check("t6_sign", 32'(MEM_SIGN), 1);
      next_cycle();
      idle();
      #1;
      check("t6_cpu_rv", 32'(CPU_RVALID), 1);
      check("t6_lbu", CPU_DOUT, 32'h000000AB);
      next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
